// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared constants and types for the SID envelope generator
package sid_pkg;

    typedef enum logic [1:0] {
        ST_ATTACK        = 2'd0,
        ST_DECAY_SUSTAIN = 2'd1,
        ST_RELEASE       = 2'd2
    } env_state_e;

    // Register offsets within a voice block
    localparam int REG_CTRL = 4;
    localparam int REG_AD   = 5;
    localparam int REG_SR   = 6;

    // Lower bound of each exponential divisor band
    localparam logic [7:0] EXP_TH_DIV1  = 8'h5E;
    localparam logic [7:0] EXP_TH_DIV2  = 8'h37;
    localparam logic [7:0] EXP_TH_DIV4  = 8'h1B;
    localparam logic [7:0] EXP_TH_DIV8  = 8'h0F;
    localparam logic [7:0] EXP_TH_DIV16 = 8'h07;

    function automatic logic [14:0] rate_period(input logic [3:0] rate);
        case (rate)
            4'd0:    rate_period = 15'd9;
            4'd1:    rate_period = 15'd32;
            4'd2:    rate_period = 15'd63;
            4'd3:    rate_period = 15'd95;
            4'd4:    rate_period = 15'd149;
            4'd5:    rate_period = 15'd220;
            4'd6:    rate_period = 15'd267;
            4'd7:    rate_period = 15'd313;
            4'd8:    rate_period = 15'd392;
            4'd9:    rate_period = 15'd977;
            4'd10:   rate_period = 15'd1954;
            4'd11:   rate_period = 15'd3126;
            4'd12:   rate_period = 15'd3907;
            4'd13:   rate_period = 15'd11720;
            4'd14:   rate_period = 15'd19532;
            default: rate_period = 15'd31251;
        endcase
    endfunction

    function automatic logic [4:0] exp_divisor(input logic [7:0] level);
        if (level >= EXP_TH_DIV1)       exp_divisor = 5'd1;
        else if (level >= EXP_TH_DIV2)  exp_divisor = 5'd2;
        else if (level >= EXP_TH_DIV4)  exp_divisor = 5'd4;
        else if (level >= EXP_TH_DIV8)  exp_divisor = 5'd8;
        else if (level >= EXP_TH_DIV16) exp_divisor = 5'd16;
        else                            exp_divisor = 5'd30;
    endfunction

endpackage

// File: rtl/sid_env_if.sv
// rtl/sid_env_if.sv - register write bus, tick enable and envelope level of one voice
interface sid_env_if;
    logic       CLKen;
    logic       WR;
    logic [4:0] ADDR;
    logic [7:0] DATA;
    logic [7:0] OUTPUT;

    modport master (output CLKen, WR, ADDR, DATA, input OUTPUT);
    modport slave  (input CLKen, WR, ADDR, DATA, output OUTPUT);
endinterface

// File: rtl/sid_env_rate.sv
// rtl/sid_env_rate.sv - 15-bit rate counter emitting one step pulse per rate period
module sid_env_rate
    import sid_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clken,
    input  logic       i_clear,
    input  logic [3:0] i_rate,
    output logic       o_step
);

    logic [14:0] r_cnt;
    logic [14:0] w_last;

    assign w_last = rate_period(i_rate) - 15'd1;
    // A clear on the same cycle as a tick suppresses the step as well as the increment
    assign o_step = i_clken && !i_clear && (r_cnt == w_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_clken) begin
            r_cnt <= (r_cnt == w_last) ? 15'd0 : r_cnt + 15'd1;
        end
    end

endmodule

// File: rtl/sid_env.sv
// rtl/sid_env.sv - per-voice ADSR envelope generator decoding its own three SID registers
module sid_env
    import sid_pkg::*;
#(
    parameter int BASE_ADDR = 0
) (
    input  logic     CLK,
    input  logic     RST,
    sid_env_if.slave bus
);

    localparam logic [4:0] A_CTRL = 5'(BASE_ADDR + REG_CTRL);
    localparam logic [4:0] A_AD   = 5'(BASE_ADDR + REG_AD);
    localparam logic [4:0] A_SR   = 5'(BASE_ADDR + REG_SR);

    logic       r_gate;
    logic [3:0] r_attack;
    logic [3:0] r_decay;
    logic [3:0] r_sustain;
    logic [3:0] r_release;
    env_state_e r_state;
    logic [7:0] r_level;
    logic [4:0] r_exp;

    logic       w_wr_ctrl;
    logic       w_wr_ad;
    logic       w_wr_sr;
    logic       w_gate_on;
    logic       w_gate_off;
    logic       w_gate_edge;
    logic       w_step;
    logic [3:0] w_rate;
    logic [7:0] w_sus_level;
    logic [4:0] w_exp_next;
    logic       w_exp_hit;

    assign w_wr_ctrl   = bus.WR && (bus.ADDR == A_CTRL);
    assign w_wr_ad     = bus.WR && (bus.ADDR == A_AD);
    assign w_wr_sr     = bus.WR && (bus.ADDR == A_SR);
    // Edges only exist relative to the last written GATE, so same-value rewrites are no-ops
    assign w_gate_on   = w_wr_ctrl &&  bus.DATA[0] && !r_gate;
    assign w_gate_off  = w_wr_ctrl && !bus.DATA[0] &&  r_gate;
    assign w_gate_edge = w_gate_on || w_gate_off;

    assign w_sus_level = {r_sustain, r_sustain};
    assign w_exp_next  = r_exp + 5'd1;
    assign w_exp_hit   = (w_exp_next == exp_divisor(r_level));

    always_comb begin
        w_rate = r_release;
        case (r_state)
            ST_ATTACK:        w_rate = r_attack;
            ST_DECAY_SUSTAIN: w_rate = r_decay;
            default:          w_rate = r_release;
        endcase
    end

    sid_env_rate u_rate (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clken (bus.CLKen),
        .i_clear (w_gate_edge),
        .i_rate  (w_rate),
        .o_step  (w_step)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gate    <= 1'b0;
            r_attack  <= '0;
            r_decay   <= '0;
            r_sustain <= '0;
            r_release <= '0;
            r_state   <= ST_RELEASE;
            r_level   <= '0;
            r_exp     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_gate <= bus.DATA[0];
            end
            if (w_wr_ad) begin
                r_attack <= bus.DATA[7:4];
                r_decay  <= bus.DATA[3:0];
            end
            if (w_wr_sr) begin
                r_sustain <= bus.DATA[7:4];
                r_release <= bus.DATA[3:0];
            end

            if (w_gate_edge) begin
                r_state <= w_gate_on ? ST_ATTACK : ST_RELEASE;
                r_exp   <= '0;
            end else if (w_step) begin
                case (r_state)
                    ST_ATTACK: begin
                        // Saturate at full scale; reaching or sitting at 0xFF hands over to decay
                        if (r_level != 8'hFF) begin
                            r_level <= r_level + 8'd1;
                        end
                        if (r_level >= 8'hFE) begin
                            r_state <= ST_DECAY_SUSTAIN;
                        end
                    end
                    ST_DECAY_SUSTAIN: begin
                        r_exp <= w_exp_hit ? 5'd0 : w_exp_next;
                        if (w_exp_hit && (r_level > w_sus_level)) begin
                            r_level <= r_level - 8'd1;
                        end
                    end
                    default: begin
                        r_exp <= w_exp_hit ? 5'd0 : w_exp_next;
                        if (w_exp_hit && (r_level != 8'h00)) begin
                            r_level <= r_level - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.OUTPUT = r_level;

endmodule

// File: tb/tb_sid_env.sv
// tb/tb_sid_env.sv - scoreboard bench for sid_env with voice blocks at base 0x00 and 0x07
module tb_sid_env;

    logic CLK;
    logic RST;

    sid_env_if bus0();
    sid_env_if bus7();

    sid_env #(.BASE_ADDR(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    sid_env #(.BASE_ADDR(7)) dut7 (.CLK(CLK), .RST(RST), .bus(bus7));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam int MA = 0;
    localparam int MD = 1;
    localparam int MR = 2;

    int PERIOD [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977,
                        1954, 3126, 3907, 11720, 19532, 31251};

    int m_gate [2];
    int m_att [2];
    int m_dec [2];
    int m_sus [2];
    int m_rel [2];
    int m_state [2];
    int m_level [2];
    int m_cnt [2];
    int m_exp [2];

    logic [7:0] q0 [$];
    logic [7:0] q7 [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int divisor_for(int lvl);
        if (lvl >= 94) return 1;
        if (lvl >= 55) return 2;
        if (lvl >= 27) return 4;
        if (lvl >= 15) return 8;
        if (lvl >= 7)  return 16;
        return 30;
    endfunction

    task automatic model_cycle(int k, bit rs, bit wr, int a, int d, bit ce);
        int  base;
        int  rate;
        int  floor_lvl;
        bit  g_on;
        bit  g_off;
        base = (k == 0) ? 0 : 7;
        if (rs) begin
            m_gate[k] = 0; m_att[k] = 0; m_dec[k] = 0; m_sus[k] = 0; m_rel[k] = 0;
            m_state[k] = MR; m_level[k] = 0; m_cnt[k] = 0; m_exp[k] = 0;
            return;
        end
        g_on  = wr && (a == base + 4) && ((d & 1) == 1) && (m_gate[k] == 0);
        g_off = wr && (a == base + 4) && ((d & 1) == 0) && (m_gate[k] == 1);
        if (g_on || g_off) begin
            m_state[k] = g_on ? MA : MR;
            m_cnt[k] = 0;
            m_exp[k] = 0;
        end else if (ce) begin
            rate = (m_state[k] == MA) ? m_att[k] : (m_state[k] == MD) ? m_dec[k] : m_rel[k];
            if (m_cnt[k] == PERIOD[rate] - 1) begin
                m_cnt[k] = 0;
                if (m_state[k] == MA) begin
                    if (m_level[k] < 255) m_level[k]++;
                    if (m_level[k] == 255) m_state[k] = MD;
                end else begin
                    m_exp[k]++;
                    if (m_exp[k] == divisor_for(m_level[k])) begin
                        m_exp[k] = 0;
                        floor_lvl = (m_state[k] == MD) ? m_sus[k] * 17 : 0;
                        if (m_level[k] > floor_lvl) m_level[k]--;
                    end
                end
            end else begin
                m_cnt[k] = (m_cnt[k] + 1) % 32768;
            end
        end
        if (wr && a == base + 4) m_gate[k] = d & 1;
        if (wr && a == base + 5) begin m_att[k] = (d >> 4) & 15; m_dec[k] = d & 15; end
        if (wr && a == base + 6) begin m_sus[k] = (d >> 4) & 15; m_rel[k] = d & 15; end
    endtask

    task automatic cyc(bit rs, bit wr, int a, int d, bit ce);
        RST = rs;
        bus0.WR = wr; bus0.ADDR = 5'(a); bus0.DATA = 8'(d); bus0.CLKen = ce;
        bus7.WR = wr; bus7.ADDR = 5'(a); bus7.DATA = 8'(d); bus7.CLKen = ce;
        @(posedge CLK);
        model_cycle(0, rs, wr, a, d, ce);
        model_cycle(1, rs, wr, a, d, ce);
        q0.push_back(8'(m_level[0]));
        q7.push_back(8'(m_level[1]));
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick_until(int target, int bound, output int n);
        n = 0;
        do begin
            cyc(0, 0, 0, 0, 1);
            n++;
        end while (bus0.OUTPUT != 8'(target) && n < bound);
    endtask

    always @(negedge CLK) begin
        logic [7:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            n_checks++;
            if (bus0.OUTPUT !== e) begin
                n_errors++;
                $display("FAIL level_base0 t=%0t: got 0x%0h expected 0x%0h", $time, bus0.OUTPUT, e);
            end
        end
        if (q7.size() > 0) begin
            e = q7.pop_front();
            n_checks++;
            if (bus7.OUTPUT !== e) begin
                n_errors++;
                $display("FAIL level_base7 t=%0t: got 0x%0h expected 0x%0h", $time, bus7.OUTPUT, e);
            end
        end
    end

    initial begin
        int n;
        int lo;
        int held;
        int addrs [7] = '{4, 5, 6, 11, 12, 13, 0};
        int a;
        int d;
        int idx;

        // Reset with a colliding gate write and a toggling tick enable
        for (int i = 0; i < 4; i++) cyc(1, 1, 4, 1, bit'(i & 1));
        chk("reset_level", int'(bus0.OUTPUT), 0);
        for (int i = 0; i < 10000; i++) cyc(0, 0, 0, 0, bit'(i & 1));
        chk("idle_level", int'(bus0.OUTPUT), 0);

        // Attack at rate 0 to full scale
        cyc(0, 1, 5, 8'h00, 0);
        cyc(0, 1, 6, 8'hF0, 0);
        cyc(0, 1, 4, 8'h01, 0);
        tick_until(8'hFF, 3000, n);
        chk("attack_ticks", n, 2295);
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 1);
        chk("attack_hold", int'(bus0.OUTPUT), 8'hFF);

        // Re-enter attack at 0xFF with sustain 8, decay 0
        cyc(0, 1, 4, 8'h00, 0);
        cyc(0, 1, 6, 8'h80, 0);
        cyc(0, 1, 4, 8'h01, 0);
        tick_until(8'hFE, 100, n);
        chk("first_decay_ticks", n, 18);
        tick_until(8'h88, 3000, n);
        chk("decay_reach", int'(bus0.OUTPUT), 8'h88);
        lo = 255;
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (int'(bus0.OUTPUT) < lo) lo = int'(bus0.OUTPUT);
        end
        chk("sustain_min", lo, 8'h88);

        // Release at rate 0 from 0x88
        cyc(0, 1, 4, 8'h00, 0);
        tick_until(8'h5D, 2000, n);
        chk("release_reach_5d", int'(bus0.OUTPUT), 8'h5D);
        tick_until(8'h5C, 100, n);
        chk("release_spacing_div2", n, 18);
        tick_until(8'h06, 6000, n);
        chk("release_reach_06", int'(bus0.OUTPUT), 8'h06);
        tick_until(8'h05, 400, n);
        chk("release_spacing_div30", n, 270);
        tick_until(8'h00, 3000, n);
        chk("release_reach_0", int'(bus0.OUTPUT), 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 1);
        chk("release_hold_0", int'(bus0.OUTPUT), 0);

        // Re-gate in the middle of a release
        cyc(0, 1, 4, 8'h01, 0);
        tick_until(8'hFF, 3000, n);
        cyc(0, 1, 4, 8'h00, 0);
        tick_until(8'h40, 5000, n);
        chk("release_reach_40", int'(bus0.OUTPUT), 8'h40);
        cyc(0, 1, 4, 8'h01, 0);
        tick_until(8'h41, 100, n);
        chk("regate_ticks", n, 9);

        // Voice block at 0x07: only 0x0B-0x0D act, and nothing moves without ticks
        chk("base7_ignored", int'(bus7.OUTPUT), 0);
        cyc(0, 1, 12, 8'h00, 0);
        cyc(0, 1, 13, 8'hF0, 0);
        cyc(0, 1, 11, 8'h01, 0);
        held = int'(bus0.OUTPUT);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, 0);
        chk("base7_no_tick", int'(bus7.OUTPUT), 0);
        chk("base0_no_tick", int'(bus0.OUTPUT), held);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
        chk("base7_first_step", int'(bus7.OUTPUT), 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 20000; i++) begin
            idx = $urandom_range(0, 6);
            a = (idx == 6) ? int'($urandom_range(0, 31)) : addrs[idx];
            d = int'($urandom_range(0, 255));
            if (a == 5 || a == 12) d = d & 8'h33;
            if (a == 6 || a == 13) d = d & 8'hF3;
            cyc(0, ($urandom_range(0, 99) < 2), a, d, bit'($urandom_range(0, 1)));
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", q0.size() + q7.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
